// File: rtl/mdu_pkg.sv
// Shared MDU opcodes and latency defaults, also used by the control and hazard units.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDUOP_NONE  = 3'd0,
        MDUOP_MULT  = 3'd1,
        MDUOP_MULTU = 3'd2,
        MDUOP_DIV   = 3'd3,
        MDUOP_DIVU  = 3'd4,
        MDUOP_MTHI  = 3'd5,
        MDUOP_MTLO  = 3'd6
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Counter width that holds the longest latency, never narrower than 4 bits.
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m + 1);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit: owns HI/LO and models fixed mult/div latency with Busy.
import mdu_pkg::*;

module mdu #(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDUStart,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    // Cleared for a divide by zero so completion leaves HI/LO untouched.
    logic             pend_wr_q, pend_wr_d;

    // Start-cycle arithmetic; the divisor is forced nonzero so the operators never see 0.
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] dvsr;
    logic signed [31:0] quot_s, rem_s;
    logic        [31:0] quot_u, rem_u;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};
    assign dvsr   = (B == 32'd0) ? 32'd1 : B;
    assign quot_s = $signed(A) / $signed(dvsr);
    assign rem_s  = $signed(A) % $signed(dvsr);
    assign quot_u = A / dvsr;
    assign rem_u  = A % dvsr;

    // Next-state: count down an operation in flight, otherwise accept a new request.
    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        if (cnt_q != '0) begin
            // Requests while busy are dropped; only the countdown advances.
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1) && pend_wr_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (MDUStart) begin
            unique case (MDUOp)
                MDUOP_MULT: begin
                    pend_hi_d = prod_s[63:32];
                    pend_lo_d = prod_s[31:0];
                    pend_wr_d = 1'b1;
                    cnt_d     = CNT_W'(MULT_CYCLES);
                end
                MDUOP_MULTU: begin
                    pend_hi_d = prod_u[63:32];
                    pend_lo_d = prod_u[31:0];
                    pend_wr_d = 1'b1;
                    cnt_d     = CNT_W'(MULT_CYCLES);
                end
                MDUOP_DIV: begin
                    pend_hi_d = rem_s;
                    pend_lo_d = quot_s;
                    pend_wr_d = (B != 32'd0);
                    cnt_d     = CNT_W'(DIV_CYCLES);
                end
                MDUOP_DIVU: begin
                    pend_hi_d = rem_u;
                    pend_lo_d = quot_u;
                    pend_wr_d = (B != 32'd0);
                    cnt_d     = CNT_W'(DIV_CYCLES);
                end
                MDUOP_MTHI: hi_d = A;
                MDUOP_MTLO: lo_d = A;
                default: ;
            endcase
        end
        busy_d = (cnt_d != '0);
    end

    // State registers with synchronous reset; reset also aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
